// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and tag type for the multiplier arbiter
//
// Contents:
//   MUL_W     operand width of the shared multiplier
//   PROD_W    product width of the shared multiplier
//   MAX_NREQ  largest supported requester count
//   ID_W      requester id width, sized for MAX_NREQ
//   tag_t     {valid, id} entry of the shadow tag pipeline
//   wrap_inc  id + 1 modulo a runtime requester count

package mult_pkg;

   localparam int MUL_W    = 16;
   localparam int PROD_W   = 32;
   localparam int MAX_NREQ = 8;
   localparam int ID_W     = $clog2(MAX_NREQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id, input int n);
      if (int'(id) == n - 1) begin
         return '0;
      end
      return id + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin winner search with registered pointer
//
// Ports:
//   sys_clk       clock, rising edge
//   sys_rst       asynchronous active-high reset (pointer -> 0)
//   req           per-requester request bits
//   en            grant enable; 0 suppresses every grant
//   grant_onehot  one-hot grant, combinational, all zero when no grant
//   grant_id      index of the winning requester (meaningful when grant_vld)
//   grant_vld     a grant is issued this cycle
//
// Every asserted request is granted in the same cycle it wins, so a grant
// is always a completed handshake and the pointer advances on grant_vld.

module rr_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] grant_onehot,
   output logic [ID_W-1:0] grant_id,
   output logic            grant_vld
);

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] win;
   logic            found;

   // Two ascending passes give a wrapping search from ptr: first the
   // indices at or above the pointer, then the ones below it.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (ID_W'(i) >= ptr)) begin
            found = 1'b1;
            win   = ID_W'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req[i] && (ID_W'(i) < ptr)) begin
            found = 1'b1;
            win   = ID_W'(i);
         end
      end
   end

   always_comb begin
      grant_vld = found & en;
      grant_id  = win;
      for (int i = 0; i < NREQ; i++) begin
         grant_onehot[i] = grant_vld && (win == ID_W'(i));
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ptr <= '0;
      end else if (grant_vld) begin
         ptr <= wrap_inc(win, NREQ);
      end
   end

endmodule

// File: rtl/mult16_rr_arbiter.sv
// rtl/mult16_rr_arbiter.sv - round-robin sharing of one pipelined 16x16 multiplier
//
// Ports:
//   sys_clk       clock, rising edge
//   sys_rst       asynchronous active-high reset
//   arb_en        1 = accept new requests, 0 = only drain in-flight work
//   req_valid     per-requester operand valid
//   req_ready     per-requester grant (combinational, at most one high)
//   req_a/req_b   packed signed operands, requester i at [16i+15:16i]
//   mul_a/mul_b   registered operands to the multiplier
//   mul_in_valid  registered, operands on mul_a/mul_b are live
//   mul_p         signed product, MUL_LAT cycles after the operands
//   rsp_valid     registered one-hot owner of rsp_p
//   rsp_p         registered product
//   idle          registered, nothing issued or in flight

module mult16_rr_arbiter
   import mult_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 3
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  arb_en,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*MUL_W-1:0] req_a,
   input  logic [NREQ*MUL_W-1:0] req_b,
   output logic [MUL_W-1:0]      mul_a,
   output logic [MUL_W-1:0]      mul_b,
   output logic                  mul_in_valid,
   input  logic [PROD_W-1:0]     mul_p,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [PROD_W-1:0]     rsp_p,
   output logic                  idle
);

   logic [NREQ-1:0] grant_onehot;
   logic [ID_W-1:0] grant_id;
   logic            grant_vld;
   logic [MUL_W-1:0] sel_a;
   logic [MUL_W-1:0] sel_b;
   logic            shadow_busy;
   logic [NREQ-1:0] rsp_onehot;

   // Entry 0 travels alongside mul_a/mul_b; entries 1..MUL_LAT shadow the
   // multiplier stages, so entry MUL_LAT lines up with mul_p.
   tag_t tag_q [MUL_LAT+1];

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .req          (req_valid),
      .en           (arb_en),
      .grant_onehot (grant_onehot),
      .grant_id     (grant_id),
      .grant_vld    (grant_vld)
   );

   assign req_ready    = grant_onehot;
   assign mul_in_valid = tag_q[0].valid;

   // One-hot grant drives an AND-OR operand mux.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_onehot[i]) begin
            sel_a = req_a[i*MUL_W +: MUL_W];
            sel_b = req_b[i*MUL_W +: MUL_W];
         end
      end
   end

   // Entries that will still be in flight after the next shift; the last
   // entry drops out as its response is launched.
   always_comb begin
      shadow_busy = 1'b0;
      for (int k = 0; k < MUL_LAT; k++) begin
         shadow_busy = shadow_busy | tag_q[k].valid;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         rsp_onehot[i] = (tag_q[MUL_LAT].id == ID_W'(i));
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mul_a     <= '0;
         mul_b     <= '0;
         rsp_valid <= '0;
         rsp_p     <= '0;
         idle      <= 1'b1;
         for (int k = 0; k <= MUL_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         if (grant_vld) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
         end
         tag_q[0] <= {grant_vld, grant_id};
         for (int k = 1; k <= MUL_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
         if (tag_q[MUL_LAT].valid) begin
            rsp_valid <= rsp_onehot;
            rsp_p     <= mul_p;
         end else begin
            rsp_valid <= '0;
         end
         idle <= !grant_vld && !shadow_busy;
      end
   end

endmodule
